store_buffer: RTL

- Write-through store queue between the EX/MA memory pipeline (downstream of the L0 data cache write path) and the single data-memory write port.
- Accepts committed stores, drains them in program order to memory, and coalesces stores to the same word.
- Forwards pending store bytes to younger loads, so memory reads never return stale data.
- Provides an empty flag for fence/MMIO ordering and for the hazard unit.

---
 rtl/store_buffer_pkg.sv | 33 +++
 rtl/store_buffer_fwd_match.sv | 51 +++++
 rtl/store_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_pkg
// Purpose  : Shared types and constants for the write-through store buffer.
// Revision : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

  localparam int StoreBufferDepth = 4;
  localparam int SbXlen           = 32;
  localparam int SbBeW            = SbXlen / 8;
  localparam int SbWaW            = SbXlen - 2;

  // One pending store, held as a whole word with its byte enables.
  typedef struct packed {
    logic [SbWaW-1:0]  word_addr;
    logic [SbXlen-1:0] data;
    logic [SbBeW-1:0]  be;
    logic              is_mmio;
  } store_buffer_entry_t;

  // Expands byte enables into a bit mask over the data word.
  function automatic logic [SbXlen-1:0] sb_be_to_mask(input logic [SbBeW-1:0] be);
    logic [SbXlen-1:0] mask;
    mask = '0;
    for (int b = 0; b < SbBeW; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_fwd_match
// Purpose  : Per-byte youngest-wins lookup of pending stores for a load.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = StoreBufferDepth,
  parameter int PW    = $clog2(DEPTH)
) (
  input  store_buffer_entry_t [DEPTH-1:0] i_entries,
  input  logic [PW-1:0]                   i_head,
  input  logic [PW:0]                     i_count,
  input  logic [SbWaW-1:0]                i_ld_word_addr,
  output logic [SbBeW-1:0]                o_covered,
  output logic [SbXlen-1:0]               o_data
);

  logic [PW-1:0]    w_idx [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_unused_mmio;

  // Age slot k maps to physical slot head+k; only the first count slots hold
  // pending stores, and only those at the load's word can supply bytes.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign w_idx[k]         = i_head + PW'(k);
      assign w_live[k]        = ((PW+1)'(k) < i_count) &&
                                (i_entries[w_idx[k]].word_addr == i_ld_word_addr);
      assign w_unused_mmio[k] = i_entries[k].is_mmio;
    end
  endgenerate

  // Walk oldest to youngest so a younger byte overwrites an older one.
  always_comb begin
    o_covered = '0;
    o_data    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < SbBeW; b++) begin
        if (w_live[k] && i_entries[w_idx[k]].be[b]) begin
          o_covered[b]     = 1'b1;
          o_data[8*b +: 8] = i_entries[w_idx[k]].data[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order write-through store queue with same-word coalescing
//            and youngest-wins store-to-load forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int               DEPTH     = StoreBufferDepth,
  parameter int               XLEN      = SbXlen,
  parameter logic [XLEN-1:0]  MMIO_ADDR = 32'h4000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_st_valid,
  output logic              o_st_ready,
  input  logic [XLEN-1:0]   i_st_addr,
  input  logic [XLEN-1:0]   i_st_data,
  input  logic [XLEN/8-1:0] i_st_be,
  output logic              o_mem_wr_valid,
  input  logic              i_mem_wr_ready,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic              i_ld_valid,
  input  logic [XLEN-1:0]   i_ld_addr,
  input  logic [XLEN/8-1:0] i_ld_be,
  output logic              o_ld_fwd_hit,
  output logic [XLEN-1:0]   o_ld_fwd_data,
  output logic              o_ld_stall,
  output logic              o_empty
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;

  store_buffer_entry_t [DEPTH-1:0] r_entries;
  logic [c_pw-1:0]                 r_head;
  logic [c_pw-1:0]                 r_tail;
  logic [c_cw-1:0]                 r_count;

  logic [c_pw-1:0]     w_tail_prev;
  store_buffer_entry_t w_last;
  store_buffer_entry_t w_new;
  store_buffer_entry_t w_merged;
  logic [XLEN-1:0]     w_st_mask;
  logic                w_full;
  logic                w_pending;
  logic                w_enq;
  logic                w_deq;
  logic                w_coalesce;
  logic                w_alloc;
  logic                w_st_mmio;
  logic                w_ld_mmio;
  logic [XLEN/8-1:0]   w_covered;
  logic [XLEN/8-1:0]   w_need;
  logic [XLEN/8-1:0]   w_miss;
  logic [XLEN-1:0]     w_fwd_data;
  logic                w_unused;

  // Byte offsets inside a word carry no information: data is already lane-aligned.
  assign w_unused = ^{i_st_addr[1:0], i_ld_addr[1:0]};

  assign w_full      = (r_count == c_cw'(DEPTH));
  assign w_pending   = (r_count != '0);
  assign w_st_mmio   = (i_st_addr >= MMIO_ADDR);
  assign w_ld_mmio   = (i_ld_addr >= MMIO_ADDR);
  assign w_tail_prev = r_tail - c_pw'(1);
  assign w_last      = r_entries[w_tail_prev];
  assign w_st_mask   = sb_be_to_mask(i_st_be);

  // No same-cycle pass-through: a full buffer refuses even while draining.
  assign w_enq = i_st_valid & ~w_full;
  assign w_deq = w_pending & i_mem_wr_ready;

  // Merging only into the youngest entry when at least two are pending keeps
  // the merge target away from the head, which may be handshaking this cycle.
  assign w_coalesce = w_enq && (r_count >= c_cw'(2)) &&
                      (w_last.word_addr == i_st_addr[XLEN-1:2]) &&
                      !w_st_mmio && !w_last.is_mmio;
  assign w_alloc    = w_enq && !w_coalesce;

  assign w_new = '{word_addr: i_st_addr[XLEN-1:2],
                   data:      i_st_data,
                   be:        i_st_be,
                   is_mmio:   w_st_mmio};

  assign w_merged = '{word_addr: w_last.word_addr,
                      data:      (w_last.data & ~w_st_mask) | (i_st_data & w_st_mask),
                      be:        w_last.be | i_st_be,
                      is_mmio:   1'b0};

  // Queue storage and pointers; reset drops every pending store.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_entries <= '0;
    end else begin
      if (w_alloc) begin
        r_entries[r_tail] <= w_new;
        r_tail            <= r_tail + c_pw'(1);
      end else if (w_coalesce) begin
        r_entries[w_tail_prev] <= w_merged;
      end
      if (w_deq) begin
        r_head <= r_head + c_pw'(1);
      end
      if (w_alloc && !w_deq) begin
        r_count <= r_count + c_cw'(1);
      end else if (!w_alloc && w_deq) begin
        r_count <= r_count - c_cw'(1);
      end
    end
  end

  store_buffer_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (c_pw)
  ) u_fwd_match (
    .i_entries      (r_entries),
    .i_head         (r_head),
    .i_count        (r_count),
    .i_ld_word_addr (i_ld_addr[XLEN-1:2]),
    .o_covered      (w_covered),
    .o_data         (w_fwd_data)
  );

  assign w_need = i_ld_be & w_covered;
  assign w_miss = i_ld_be & ~w_covered;

  // Memory side presents the head entry; outputs are forced quiet during reset.
  assign o_mem_wr_valid = w_pending & ~i_rst;
  assign o_mem_addr     = {r_entries[r_head].word_addr, 2'b00};
  assign o_mem_wdata    = r_entries[r_head].data;
  assign o_mem_be       = r_entries[r_head].be;
  assign o_st_ready     = ~w_full | i_rst;
  assign o_empty        = ~w_pending | i_rst;

  // An MMIO load must wait for every older store; otherwise full coverage hits
  // and partial coverage stalls, which keeps hit and stall mutually exclusive.
  assign o_ld_fwd_hit  = i_ld_valid & ~i_rst & (w_miss == '0) & (w_need != '0) &
                         ~(w_ld_mmio & w_pending);
  assign o_ld_stall    = i_ld_valid & ~i_rst &
                         (((w_need != '0) & (w_miss != '0)) | (w_ld_mmio & w_pending));
  assign o_ld_fwd_data = i_rst ? '0 : w_fwd_data;

endmodule
`default_nettype wire
